spi_master_param: RTL and testbench

Parametrised, single-clock SPI master for the FPGA register fabric. Successor to the fixed 16-bit mode-0 master: configurable word width, SCK divider, all four CPOL/CPHA modes, bit order and multiple slave selects. Derives SCK as a registered output inside the `clk` domain, so there is no derived clock. Keeps the existing word-in/accept and request/strobe handshakes so current clients port unchanged.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clkgen.sv | 40 ++++
 rtl/spi_master_param.sv | 175 +++++++++++++++++
 tb/tb_spi_master_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int unsigned CPHA_BIT = 0;
    localparam int unsigned CPOL_BIT = 1;

    function automatic int unsigned ss_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer and registered SCK generator for spi_master_param.
module spi_clkgen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             tog_en,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    output logic             half_tick,
    output logic             lead_edge,
    output logic             trail_edge,
    output logic             sck
);

    logic [DIV_W-1:0] cnt;

    // Strobes are asserted in the cycle before the clk edge on which sck toggles.
    assign half_tick  = en && (cnt == div);
    assign lead_edge  = half_tick && tog_en && (sck == cpol);
    assign trail_edge = half_tick && tog_en && (sck != cpol);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            if (!en || half_tick)
                cnt <= '0;
            else
                cnt <= cnt + DIV_W'(1);
            if (!en)
                sck <= cpol;
            else if (lead_edge || trail_edge)
                sck <= ~sck;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: FSM, shift registers and client handshakes.
// Optional SPI_MASTER_MISO_SYNC_EN adds a two-flop MISO synchronizer.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_SS = 1,
    parameter int unsigned DIV_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic                      cfg_cpol,
    input  logic                      cfg_cpha,
    input  logic                      cfg_lsb_first,
    input  logic [ss_w(NUM_SS)-1:0]   cfg_ss_sel,
    input  logic [WIDTH-1:0]          rx_data,
    input  logic                      rx_strobe,
    output logic                      rx_accept,
    input  logic                      tx_request,
    output logic [WIDTH-1:0]          tx_data,
    output logic                      tx_strobe,
    output logic                      busy,
    output logic [NUM_SS-1:0]         ss,
    output logic                      sck,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int unsigned SSW  = ss_w(NUM_SS);
    localparam int unsigned HC_W = $clog2(2 * WIDTH);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * WIDTH - 1);

    state_t           state, state_nx;
    logic [DIV_W-1:0] div_l, div_eff;
    logic [1:0]       mode_l;
    logic             lsb_l, capture;
    logic [WIDTH-1:0] sreg, rreg, load_w;
    logic [HC_W-1:0]  hcnt;
    logic             start, en, tog_en, cpol_cur;
    logic             half_tick, lead_edge, trail_edge;
    logic             sample_edge, drive_edge, samp_now, samp_bit;

    function automatic logic [WIDTH-1:0] shift_w(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? {1'b1, v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b1};
    endfunction

    function automatic logic first_bit(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SSW-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < NUM_SS; i++)
            if (sel == SSW'(i)) v[i] = 1'b0;
        return v;
    endfunction

    assign start       = (state == ST_IDLE) && (rx_strobe || tx_request);
    assign en          = (state == ST_SETUP) || (state == ST_SHIFT) ||
                         (state == ST_HOLD)  || (state == ST_GAP);
    // SETUP's final tick is the first SCK edge; the last SHIFT half-period ends at idle level.
    assign tog_en      = (state == ST_SETUP) || ((state == ST_SHIFT) && (hcnt != HC_LAST));
    assign cpol_cur    = (state == ST_IDLE) ? cfg_cpol : mode_l[CPOL_BIT];
    assign sample_edge = mode_l[CPHA_BIT] ? trail_edge : lead_edge;
    assign drive_edge  = mode_l[CPHA_BIT] ? lead_edge : trail_edge;
    assign load_w      = rx_strobe ? rx_data : '1;
    assign busy        = (state != ST_IDLE);

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync, samp_dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso_sync <= '0;
            samp_dly  <= '0;
        end else begin
            miso_sync <= {miso_sync[0], miso};
            samp_dly  <= {samp_dly[0], sample_edge};
        end
    end

    assign samp_bit = miso_sync[1];
    assign samp_now = samp_dly[1];
    assign div_eff  = (div_l < DIV_W'(2)) ? DIV_W'(2) : div_l;
`else
    assign samp_bit = miso;
    assign samp_now = sample_edge;
    assign div_eff  = div_l;
`endif

    spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .tog_en     (tog_en),
        .div        (div_eff),
        .cpol       (cpol_cur),
        .half_tick  (half_tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .sck        (sck)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_SETUP;
            ST_SETUP: if (half_tick) state_nx = ST_SHIFT;
            ST_SHIFT: if (half_tick && (hcnt == HC_LAST)) state_nx = ST_HOLD;
            ST_HOLD:  if (half_tick) state_nx = ST_GAP;
            ST_GAP:   if (half_tick) state_nx = ST_DONE;
            ST_DONE:  if (!capture || !tx_request) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rx_accept <= 1'b0;
            tx_strobe <= 1'b0;
            tx_data   <= '0;
            ss        <= '1;
            mosi      <= 1'b1;
            div_l     <= '0;
            mode_l    <= '0;
            lsb_l     <= 1'b0;
            capture   <= 1'b0;
            sreg      <= '1;
            rreg      <= '0;
            hcnt      <= '0;
        end else begin
            state     <= state_nx;
            rx_accept <= start && rx_strobe;
            if (start) begin
                div_l            <= cfg_div;
                mode_l[CPOL_BIT] <= cfg_cpol;
                mode_l[CPHA_BIT] <= cfg_cpha;
                lsb_l            <= cfg_lsb_first;
                capture          <= tx_request;
                ss               <= ss_decode(cfg_ss_sel);
                hcnt             <= '0;
                if (cfg_cpha) begin
                    sreg <= load_w;
                    mosi <= 1'b1;
                end else begin
                    sreg <= shift_w(load_w, cfg_lsb_first);
                    mosi <= first_bit(load_w, cfg_lsb_first);
                end
            end else begin
                if (state == ST_IDLE)
                    mosi <= 1'b1;
                else if (drive_edge) begin
                    mosi <= first_bit(sreg, lsb_l);
                    sreg <= shift_w(sreg, lsb_l);
                end
                if ((state == ST_SHIFT) && half_tick)
                    hcnt <= hcnt + HC_W'(1);
                if (samp_now)
                    rreg <= lsb_l ? {samp_bit, rreg[WIDTH-1:1]} : {rreg[WIDTH-2:0], samp_bit};
                if ((state == ST_HOLD) && half_tick) begin
                    tx_data <= rreg;
                    ss      <= '1;
                end
                if ((state == ST_GAP) && half_tick && capture)
                    tx_strobe <= 1'b1;
                else if ((state == ST_DONE) && !tx_request)
                    tx_strobe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed self-checking bench for spi_master_param (WIDTH=16, NUM_SS=4).
module tb_spi_master_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cfg_div;
    logic        cfg_cpol, cfg_cpha, cfg_lsb_first;
    logic [1:0]  cfg_ss_sel;
    logic [15:0] rx_data;
    logic        rx_strobe, rx_accept, tx_request, tx_strobe, busy;
    logic [15:0] tx_data;
    logic [3:0]  ss;
    logic        sck, mosi;
    logic        miso = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    spi_master_param #(.WIDTH(16), .NUM_SS(4), .DIV_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_div       (cfg_div),
        .cfg_cpol      (cfg_cpol),
        .cfg_cpha      (cfg_cpha),
        .cfg_lsb_first (cfg_lsb_first),
        .cfg_ss_sel    (cfg_ss_sel),
        .rx_data       (rx_data),
        .rx_strobe     (rx_strobe),
        .rx_accept     (rx_accept),
        .tx_request    (tx_request),
        .tx_data       (tx_data),
        .tx_strobe     (tx_strobe),
        .busy          (busy),
        .ss            (ss),
        .sck           (sck),
        .mosi          (mosi),
        .miso          (miso)
    );

    always #5 clk = ~clk;

    // Slave model: returns s_word on MISO and collects MOSI in wire order.
    logic        t_cpol = 1'b0, t_cpha = 1'b0, t_lsb = 1'b0;
    logic [15:0] s_word = '0;
    logic [15:0] m_word = '0;
    int          s_idx = 0, m_bits = 0;
    logic        ss_all, ss_all_q = 1'b1, sck_q = 1'b0, lead;
    assign ss_all = &ss;

    function automatic logic s_bit(input int i);
        return t_lsb ? s_word[i] : s_word[15-i];
    endfunction

    always @(sck or ss_all) begin
        if (ss_all_q && !ss_all) begin
            s_idx = 0; m_bits = 0; m_word = '0;
            if (!t_cpha) begin miso = s_bit(0); s_idx = 1; end
        end else if (!ss_all && sck !== sck_q) begin
            lead = (sck != t_cpol);
            if (lead != t_cpha) begin m_word = {m_word[14:0], mosi}; m_bits++; end
            if (lead == t_cpha && s_idx < 16) begin miso = s_bit(s_idx); s_idx++; end
        end
        ss_all_q = ss_all;
        sck_q = sck;
    end

    int ss_low_cnt = 0, acc_cnt = 0, ts_cnt = 0;
    always @(negedge clk) begin
        if (!ss_all) ss_low_cnt++;
        if (rx_accept) acc_cnt++;
        if (tx_strobe) ts_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup_cfg(input logic [7:0] div, input logic cpol, input logic cpha,
                             input logic lsb, input logic [1:0] sel);
        @(negedge clk);
        cfg_div = div; cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb; cfg_ss_sel = sel;
        t_cpol = cpol; t_cpha = cpha; t_lsb = lsb;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < max);
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, g, ss0, acc0, ts0;
        logic s4, s5, s9, s13;
        logic [3:0] ss1;

        reset = 1'b1; cfg_div = '0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
        cfg_ss_sel = '0; rx_data = '0; rx_strobe = 1'b0; tx_request = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 32'(sck), 0);
        chk("rst_mosi", 32'(mosi), 1);
        chk("rst_ss", 32'(ss), 32'hF);
        chk("rst_rx_accept", 32'(rx_accept), 0);
        chk("rst_tx_strobe", 32'(tx_strobe), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        // Mode 0, MSB-first, H=1
        setup_cfg(8'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        s_word = 16'h1234;
        ss0 = ss_low_cnt; acc0 = acc_cnt; ts0 = ts_cnt;
        rx_data = 16'hA53C; rx_strobe = 1'b1;
        @(negedge clk);
        chk("m0_accept", 32'(rx_accept), 1);
        chk("m0_busy", 32'(busy), 1);
        chk("m0_ss", 32'(ss), 32'hE);
        chk("m0_sck_setup", 32'(sck), 0);
        rx_strobe = 1'b0;
        @(negedge clk);
        chk("m0_first_edge", 32'(sck), 1);
        chk("m0_accept_pulse", 32'(rx_accept), 0);
        wait_idle("m0_done", 100);
        chk("m0_mosi_word", 32'(m_word), 32'hA53C);
        chk("m0_bits", 32'(m_bits), 16);
        chk("m0_tx_data", 32'(tx_data), 32'h1234);
        chk("m0_ss_low_cycles", 32'(ss_low_cnt - ss0), 34);
        chk("m0_accept_count", 32'(acc_cnt - acc0), 1);
        chk("m0_no_strobe", 32'(ts_cnt - ts0), 0);

        // Mode 3, LSB-first, H=4, read only
        setup_cfg(8'd3, 1'b1, 1'b1, 1'b1, 2'd1);
        chk("m3_idle_sck", 32'(sck), 1);
        s_word = 16'hC3A5;
        tx_request = 1'b1;
        n = 0; s4 = 1'b0; s5 = 1'b0; s9 = 1'b0; s13 = 1'b0; ss1 = '0;
        do begin
            @(negedge clk); n++;
            if (n == 1) ss1 = ss;
            if (n == 4) s4 = sck;
            if (n == 5) s5 = sck;
            if (n == 9) s9 = sck;
            if (n == 13) s13 = sck;
        end while (!tx_strobe && n < 300);
        chk("m3_ss", 32'(ss1), 32'hD);
        chk("m3_sck_c4", 32'(s4), 1);
        chk("m3_sck_c5", 32'(s5), 0);
        chk("m3_sck_c9", 32'(s9), 1);
        chk("m3_sck_c13", 32'(s13), 0);
        chk("m3_strobe_latency", 32'(n), 141);
        chk("m3_tx_data", 32'(tx_data), 32'hC3A5);
        chk("m3_mosi_ones", 32'(m_word), 32'hFFFF);
        chk("m3_bits", 32'(m_bits), 16);
        repeat (3) @(negedge clk);
        chk("m3_strobe_held", 32'(tx_strobe), 1);
        chk("m3_busy_held", 32'(busy), 1);
        tx_request = 1'b0;
        @(negedge clk);
        chk("m3_strobe_clear", 32'(tx_strobe), 0);
        chk("m3_idle", 32'(busy), 0);

        // Select routing
        setup_cfg(8'd0, 1'b0, 1'b0, 1'b0, 2'd2);
        rx_data = 16'h0001; rx_strobe = 1'b1;
        @(negedge clk);
        chk("sel2_ss", 32'(ss), 32'hB);
        rx_strobe = 1'b0;
        wait_idle("sel2_done", 100);
        setup_cfg(8'd0, 1'b0, 1'b0, 1'b0, 2'd3);
        rx_strobe = 1'b1;
        @(negedge clk);
        chk("sel3_ss", 32'(ss), 32'h7);
        rx_strobe = 1'b0;
        wait_idle("sel3_done", 100);

        // CPHA change mid-word takes effect only on the next word
        setup_cfg(8'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        s_word = 16'h3C71; rx_data = 16'h5A96; rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        repeat (10) @(negedge clk);
        cfg_cpha = 1'b1;
        wait_idle("cfg_w1_done", 200);
        chk("cfg_w1_mosi", 32'(m_word), 32'h5A96);
        chk("cfg_w1_tx_data", 32'(tx_data), 32'h3C71);
        setup_cfg(8'd1, 1'b0, 1'b1, 1'b0, 2'd0);
        s_word = 16'h9E2B; rx_data = 16'h6D14; rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        wait_idle("cfg_w2_done", 200);
        chk("cfg_w2_mosi", 32'(m_word), 32'h6D14);
        chk("cfg_w2_tx_data", 32'(tx_data), 32'h9E2B);

        // Reset during bit 7
        setup_cfg(8'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        ts0 = ts_cnt;
        rx_data = 16'h0000; rx_strobe = 1'b1; tx_request = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        repeat (16) @(negedge clk);
        chk("rstmid_pre_sck", 32'(sck), 1);
        chk("rstmid_pre_mosi", 32'(mosi), 0);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_sck", 32'(sck), 0);
        chk("rstmid_mosi", 32'(mosi), 1);
        chk("rstmid_ss", 32'(ss), 32'hF);
        chk("rstmid_busy", 32'(busy), 0);
        tx_request = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmid_no_strobe", 32'(ts_cnt - ts0), 0);
        setup_cfg(8'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        s_word = 16'hF0F1; rx_data = 16'h0F0F; rx_strobe = 1'b1; tx_request = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_strobe && n < 100);
        chk("fresh_strobe", 32'(tx_strobe), 1);
        chk("fresh_tx_data", 32'(tx_data), 32'hF0F1);
        chk("fresh_mosi", 32'(m_word), 32'h0F0F);
        tx_request = 1'b0;
        wait_idle("fresh_done", 10);

        // Back-to-back words with rx_strobe held, H=3
        setup_cfg(8'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        s_word = 16'h5555; acc0 = acc_cnt;
        rx_data = 16'h1111; rx_strobe = 1'b1;
        @(negedge clk);
        chk("b2b_accept1", 32'(rx_accept), 1);
        rx_data = 16'h2222;
        n = 0;
        do begin @(negedge clk); n++; end while (!ss_all && n < 200);
        g = 1;
        while (ss_all && g < 50) begin @(negedge clk); if (ss_all) g++; end
        chk("b2b_gap_cycles", 32'(g), 5);
        chk("b2b_accept2", 32'(rx_accept), 1);
        rx_strobe = 1'b0;
        wait_idle("b2b_done", 300);
        chk("b2b_accept_count", 32'(acc_cnt - acc0), 2);
        chk("b2b_mosi2", 32'(m_word), 32'h2222);
        chk("b2b_tx_data", 32'(tx_data), 32'h5555);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
